// File: rtl/data_memory_bhw.sv
// data_memory_bhw: byte-addressed little-endian data memory with registered loads and a handshaked dump port.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress misaligned half/word accesses instead of force-aligning them.
module data_memory_bhw #(
  parameter int NB_DATA      = 32,
  parameter int MEMORY_DEPTH = 32,
  parameter int NB_ADDR      = 7,
  parameter int NB_WADDR     = 5
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_mem_write,
  input  logic                i_mem_read,
  input  logic [1:0]          i_size,
  input  logic                i_signed,
  input  logic [NB_ADDR-1:0]  i_address,
  input  logic [NB_DATA-1:0]  i_write_data,
  output logic [NB_DATA-1:0]  o_read_data,
  output logic                o_misaligned,
  input  logic                i_dump_start,
  input  logic                i_dump_ready,
  output logic                o_dump_valid,
  output logic [NB_WADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0]  o_dump_data,
  output logic                o_dump_done
);

  // state | meaning
  // IDLE  | waiting for i_dump_start
  // DUMP  | presenting word[dump_addr] until the consumer accepts it
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, DUMP, DONE} dump_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [NB_WADDR-1:0] LAST_IDX = NB_WADDR'(MEMORY_DEPTH - 1);

  logic [NB_DATA-1:0] mem [MEMORY_DEPTH] = '{default: '0};

  logic [NB_WADDR-1:0] word_idx;
  logic [1:0]          lane_raw;
  logic [1:0]          lane;
  logic                misaligned;

  assign word_idx = i_address[NB_ADDR-1:2];
  assign lane_raw = i_address[1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign lane = lane_raw;
  always_comb begin
    misaligned = 1'b0;
    if (i_size == SIZE_HALF)
      misaligned = lane_raw[0];
    else if (i_size[1])
      misaligned = (lane_raw != 2'b00);
  end
`else
  // Without the check, low address bits are dropped to the access alignment.
  always_comb begin
    lane = lane_raw;
    if (i_size == SIZE_HALF)
      lane = {lane_raw[1], 1'b0};
    else if (i_size[1])
      lane = 2'b00;
  end
  assign misaligned = 1'b0;
`endif

  logic [3:0]         byte_en;
  logic [NB_DATA-1:0] store_word;

  always_comb begin
    byte_en    = 4'b1111;
    store_word = i_write_data;
    case (i_size)
      SIZE_BYTE: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{i_write_data[7:0]}};
      end
      SIZE_HALF: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_word = {2{i_write_data[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_word = i_write_data;
      end
    endcase
  end

  logic do_store;
  assign do_store = i_enable & i_mem_write & ~misaligned;

  always_ff @(posedge i_clock) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
    end
  end

  logic [NB_DATA-1:0] cur_word;
  logic [NB_DATA-1:0] load_value;
  logic [7:0]         load_byte;
  logic [15:0]        load_half;

  assign cur_word  = mem[word_idx];
  assign load_byte = cur_word[8*lane +: 8];
  assign load_half = lane[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    load_value = cur_word;
    if (misaligned)
      load_value = '0;
    else if (i_size == SIZE_BYTE)
      load_value = {{24{i_signed & load_byte[7]}}, load_byte};
    else if (i_size == SIZE_HALF)
      load_value = {{16{i_signed & load_half[15]}}, load_half};
  end

  // Reads sample the array before this edge's store lands, giving read-first behaviour.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_read_data  <= '0;
      o_misaligned <= 1'b0;
    end else if (i_enable) begin
      o_read_data <= i_mem_read ? load_value : '0;
      if (i_mem_read | i_mem_write)
        o_misaligned <= misaligned;
    end
  end

  dump_state_t         state, state_next;
  logic [NB_WADDR-1:0] dump_addr, dump_addr_next;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      dump_addr <= '0;
    end else begin
      state     <= state_next;
      dump_addr <= dump_addr_next;
    end
  end

  always_comb begin
    state_next     = state;
    dump_addr_next = dump_addr;
    case (state)
      IDLE: begin
        if (i_dump_start) begin
          state_next     = DUMP;
          dump_addr_next = '0;
        end
      end
      DUMP: begin
        if (i_dump_ready) begin
          if (dump_addr == LAST_IDX)
            state_next = DONE;
          else
            dump_addr_next = dump_addr + 1'b1;
        end
      end
      DONE: begin
        state_next     = IDLE;
        dump_addr_next = '0;
      end
      default: begin
        state_next     = IDLE;
        dump_addr_next = '0;
      end
    endcase
  end

  assign o_dump_valid = (state == DUMP);
  assign o_dump_done  = (state == DONE);
  assign o_dump_addr  = dump_addr;
  assign o_dump_data  = mem[dump_addr];

endmodule

// File: tb/tb_data_memory_bhw.sv
// tb_data_memory_bhw: randomized and directed checks of data_memory_bhw against an array-based reference model.
module tb_data_memory_bhw;
  localparam int NB_DATA = 32, MEMORY_DEPTH = 32, NB_ADDR = 7, NB_WADDR = 5;

  logic                clock = 1'b0;
  logic                reset, enable, mem_write, mem_read, sgn;
  logic [1:0]          size;
  logic [NB_ADDR-1:0]  address;
  logic [NB_DATA-1:0]  write_data, read_data, dump_data;
  logic                misaligned, dump_start, dump_ready, dump_valid, dump_done;
  logic [NB_WADDR-1:0] dump_addr;

  always #5 clock = ~clock;

  data_memory_bhw #(
    .NB_DATA(NB_DATA), .MEMORY_DEPTH(MEMORY_DEPTH), .NB_ADDR(NB_ADDR), .NB_WADDR(NB_WADDR)
  ) dut (
    .i_clock(clock), .i_reset(reset), .i_enable(enable), .i_mem_write(mem_write),
    .i_mem_read(mem_read), .i_size(size), .i_signed(sgn), .i_address(address),
    .i_write_data(write_data), .o_read_data(read_data), .o_misaligned(misaligned),
    .i_dump_start(dump_start), .i_dump_ready(dump_ready), .o_dump_valid(dump_valid),
    .o_dump_addr(dump_addr), .o_dump_data(dump_data), .o_dump_done(dump_done)
  );

  int checks = 0, failures = 0;
  logic [31:0] model [MEMORY_DEPTH];
  logic [31:0] last_rd;
  logic        last_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mis(input logic [1:0] sz, input logic [6:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (sz == 2'b01) return a[0];
    if (sz[1]) return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic s, input logic [6:0] a);
    int w = a / 4;
    int ln = a % 4;
    logic [31:0] v;
    if (is_mis(sz, a)) return 32'h0;
    if (sz == 2'b00) begin
      v = (model[w] >> (8 * ln)) & 32'hFF;
      if (s && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (model[w] >> (16 * (ln / 2))) & 32'hFFFF;
      if (s && v[15]) v = v | 32'hFFFF_0000;
    end else
      v = model[w];
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [6:0] a, input logic [31:0] d);
    int w = a / 4;
    int ln = a % 4;
    logic [31:0] mask;
    if (is_mis(sz, a)) return;
    if (sz == 2'b00) begin
      mask = 32'hFF << (8 * ln);
      model[w] = (model[w] & ~mask) | ((d & 32'hFF) << (8 * ln));
    end else if (sz == 2'b01) begin
      mask = 32'hFFFF << (16 * (ln / 2));
      model[w] = (model[w] & ~mask) | ((d & 32'hFFFF) << (16 * (ln / 2)));
    end else
      model[w] = d;
  endtask

  // Called just after a falling edge; applies one cycle of CPU stimulus and checks the result.
  task automatic cpu_op(input string tag, input logic en, input logic we, input logic re,
                        input logic [1:0] sz, input logic s, input logic [6:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    logic        exp_mis;
    enable = en; mem_write = we; mem_read = re; size = sz; sgn = s; address = a; write_data = d;
    exp_rd  = last_rd;
    exp_mis = last_mis;
    if (en) begin
      exp_rd = re ? model_load(sz, s, a) : 32'h0;
      if (re || we) exp_mis = is_mis(sz, a);
    end
    @(negedge clock);
    check({tag, "_rd"}, read_data, exp_rd);
    check({tag, "_mis"}, {31'h0, misaligned}, {31'h0, exp_mis});
    if (en && we) model_store(sz, a, d);
    last_rd = exp_rd;
    last_mis = exp_mis;
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_rd = 32'h0;
    last_mis = 1'b0;
  endtask

  initial begin
    int beats, dones, guard;
    logic reached;
    reset = 1'b1; enable = 1'b0; mem_write = 1'b0; mem_read = 1'b0; size = 2'b10; sgn = 1'b0;
    address = '0; write_data = '0; dump_start = 1'b0; dump_ready = 1'b0;
    last_rd = 32'h0; last_mis = 1'b0;
    for (int i = 0; i < MEMORY_DEPTH; i++) model[i] = 32'h0;
    repeat (2) @(negedge clock);
    check("rst_rd", read_data, 32'h0);
    check("rst_mis", {31'h0, misaligned}, 32'h0);
    check("rst_valid", {31'h0, dump_valid}, 32'h0);
    check("rst_addr", {27'h0, dump_addr}, 32'h0);
    check("rst_done", {31'h0, dump_done}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < MEMORY_DEPTH; i++) cpu_op("clr", 1, 1, 0, 2'b10, 0, 7'(i * 4), 32'h0);

    cpu_op("sw08", 1, 1, 0, 2'b10, 0, 7'h08, 32'hDEADBEEF);
    cpu_op("lw08", 1, 0, 1, 2'b10, 0, 7'h08, 32'h0);
    check("lw08_direct", read_data, 32'hDEADBEEF);
    cpu_op("sw04", 1, 1, 0, 2'b10, 0, 7'h04, 32'h0);
    cpu_op("sb05", 1, 1, 0, 2'b00, 0, 7'h05, 32'h80);
    cpu_op("lw04", 1, 0, 1, 2'b10, 0, 7'h04, 32'h0);
    check("lw04_direct", read_data, 32'h0000_8000);
    cpu_op("lb05", 1, 0, 1, 2'b00, 1, 7'h05, 32'h0);
    check("lb05_direct", read_data, 32'hFFFF_FF80);
    cpu_op("lbu05", 1, 0, 1, 2'b00, 0, 7'h05, 32'h0);
    check("lbu05_direct", read_data, 32'h0000_0080);
    cpu_op("sh0e", 1, 1, 0, 2'b01, 0, 7'h0E, 32'h8001);
    cpu_op("lh0e", 1, 0, 1, 2'b01, 1, 7'h0E, 32'h0);
    check("lh0e_direct", read_data, 32'hFFFF_8001);
    cpu_op("lhu0e", 1, 0, 1, 2'b01, 0, 7'h0E, 32'h0);
    check("lhu0e_direct", read_data, 32'h0000_8001);
    cpu_op("lw0c", 1, 0, 1, 2'b10, 0, 7'h0C, 32'h0);
    check("lw0c_direct", read_data, 32'h8001_0000);
    cpu_op("sw09", 1, 1, 0, 2'b10, 0, 7'h09, 32'h12345678);
    cpu_op("lw08b", 1, 0, 1, 2'b10, 0, 7'h08, 32'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("sw09_suppressed", read_data, 32'hDEADBEEF);
`else
    check("sw09_aligned", read_data, 32'h12345678);
`endif
    cpu_op("rdfirst", 1, 1, 1, 2'b10, 0, 7'h10, 32'hCAFEF00D);
    cpu_op("hold", 0, 1, 1, 2'b10, 0, 7'h10, 32'h11111111);
    cpu_op("after_hold", 1, 0, 1, 2'b10, 0, 7'h10, 32'h0);
    cpu_op("idle_en", 1, 0, 0, 2'b10, 0, 7'h10, 32'h0);

    for (int n = 0; n < 400; n++)
      cpu_op("rnd", ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
             1'($urandom), 7'($urandom), $urandom);

    // Dump with ready toggling every cycle.
    for (int k = 0; k < MEMORY_DEPTH; k++) cpu_op("pre", 1, 1, 0, 2'b10, 0, 7'(k * 4), 32'(k + 1));
    dump_start = 1'b1;
    @(negedge clock);
    dump_start = 1'b0;
    beats = 0; dones = 0;
    for (int c = 0; c < 200; c++) begin
      dump_ready = c[0];
      if (dump_done) dones++;
      if (dump_valid && dump_ready) begin
        check("dump_addr", {27'h0, dump_addr}, 32'(beats));
        check("dump_data", dump_data, model[beats % MEMORY_DEPTH]);
        beats++;
      end
      @(negedge clock);
    end
    dump_ready = 1'b0;
    check("dump_beats", 32'(beats), 32'(MEMORY_DEPTH));
    check("dump_dones", 32'(dones), 32'd1);
    check("dump_valid_end", {31'h0, dump_valid}, 32'h0);

    // Reset in the middle of a dump, then restart.
    dump_start = 1'b1; dump_ready = 1'b1;
    @(negedge clock);
    dump_start = 1'b0;
    reached = 1'b0;
    for (guard = 0; guard < 50 && !reached; guard++) begin
      if (dump_addr == 5'd10 && dump_valid) reached = 1'b1;
      else @(negedge clock);
    end
    check("reach_idx10", {31'h0, reached}, 32'h1);
    pulse_reset();
    check("midrst_valid", {31'h0, dump_valid}, 32'h0);
    check("midrst_addr", {27'h0, dump_addr}, 32'h0);
    check("midrst_done", {31'h0, dump_done}, 32'h0);
    dump_start = 1'b1;
    @(negedge clock);
    dump_start = 1'b0;
    check("restart_valid", {31'h0, dump_valid}, 32'h1);
    check("restart_addr", {27'h0, dump_addr}, 32'h0);
    check("restart_data", dump_data, model[0]);
    beats = 0; dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (dump_done) dones++;
      if (dump_valid) beats++;
      @(negedge clock);
    end
    dump_ready = 1'b0;
    check("restart_beats", 32'(beats), 32'(MEMORY_DEPTH));
    check("restart_dones", 32'(dones), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_memory_bhw.md
Name: data_memory_bhw

Overview:
- Parametrised data memory for the MIPS pipeline MEM stage; successor to the word-only data memory.
- Byte-addressed, little-endian, with byte/half/word loads and stores, sign/zero extension and a registered read port.
- Adds a debug dump port: a handshaked state machine that streams every word to the debug unit after the program halts.

Parameters:
- NB_DATA, 32, data word width in bits; must be 32.
- MEMORY_DEPTH, 32, number of words; power of two, at least 2.
- NB_ADDR, 7, byte-address width; equals log2(MEMORY_DEPTH)+2.
- NB_WADDR, 5, word-index width; equals log2(MEMORY_DEPTH).

Ports:
- i_clock  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  CPU port enable; when low the CPU port is frozen.
- i_mem_write  in  1  store strobe.
- i_mem_read  in  1  load strobe.
- i_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- i_signed  in  1  1 means sign-extend loads, 0 means zero-extend.
- i_address  in  NB_ADDR  byte address.
- i_write_data  in  NB_DATA  store data, right-aligned.
- o_read_data  out  NB_DATA  registered load result.
- o_misaligned  out  1  registered misaligned-access flag.
- i_dump_start  in  1  pulse that starts a dump.
- i_dump_ready  in  1  consumer ready.
- o_dump_valid  out  1  dump word valid.
- o_dump_addr  out  NB_WADDR  word index being presented.
- o_dump_data  out  NB_DATA  word at o_dump_addr.
- o_dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Clock and reset: one clock, i_clock; i_reset is synchronous, active-high.
- Reset values: o_read_data=0, o_misaligned=0, o_dump_valid=0, o_dump_addr=0, o_dump_done=0, FSM=IDLE.
- Memory contents are not cleared by reset; they are zero-initialised at configuration.
- Addressing: word index = i_address[NB_ADDR-1:2]; byte lane = i_address[1:0], with lane 0 holding bits 7:0.
- Store, when i_enable and i_mem_write: byte writes write_data[7:0] into lane addr[1:0]; half writes write_data[15:0] into lanes {addr[1],0}; word writes all four lanes. Other lanes are unchanged.
- Load, when i_enable and i_mem_read:
  - o_read_data is updated at the next edge (latency 1).
  - The selected byte or half is right-aligned, then sign- or zero-extended per i_signed.
  - For word loads, i_signed is ignored.
- When i_enable is high and i_mem_read is low, o_read_data is 0 at the next edge.
- When i_enable is low, o_read_data and o_misaligned hold, and no write occurs.
- Same-cycle load and store to the same word is read-first: the load returns the pre-store data.
- Dump FSM:
  - IDLE to DUMP on i_dump_start; the index is loaded with 0.
  - In DUMP, o_dump_valid=1 and o_dump_data is the combinational read of word[o_dump_addr].
  - When valid and ready are both high, the index increments.
  - Acceptance at index MEMORY_DEPTH-1 moves to DONE.
  - DONE asserts o_dump_done for one cycle, then returns to IDLE with the index reset to 0.
  - i_dump_start is ignored outside IDLE.
- The CPU port stays fully functional during a dump. A store to the word currently presented changes o_dump_data in the cycle after the write.
- i_reset mid-dump: at the next edge, FSM=IDLE, valid=0, index=0, no done pulse.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- With the macro defined:
  - Half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 set o_misaligned=1 at the next edge.
  - A misaligned store is suppressed (memory unchanged).
  - A misaligned load returns o_read_data=0.
  - o_misaligned is cleared by the next enabled aligned access.
- Without the macro: the low address bits are forced to alignment (bit 0 for half, bits 1:0 for word), the access proceeds normally, and o_misaligned is tied to 0.

Test Plan:
- Word round trip: sw 0xDEADBEEF to 0x08, then lw 0x08 → o_read_data=0xDEADBEEF one cycle after the load strobe.
- Byte lanes and extension: sw 0 to 0x04; sb 0x80 to 0x05; lw 0x04 → 0x00008000; lb 0x05 → 0xFFFFFF80; lbu 0x05 → 0x00000080.
- Halfword: sh 0x8001 to 0x0E; lh 0x0E → 0xFFFF8001; lhu 0x0E → 0x00008001; lw 0x0C → 0x80010000.
- Misaligned (macro on): sw 0x12345678 to 0x09 → o_misaligned=1 and word 2 unchanged. Macro off: the same store writes word 2 = 0x12345678.
- Dump with backpressure:
  - Preload word k = k+1; pulse i_dump_start; toggle i_dump_ready every other cycle.
  - Require 32 accepted beats carrying data 1..32 in index order.
  - o_dump_done pulses exactly once; valid returns to 0.
- Reset mid-dump: assert i_reset at index 10 → valid=0 and addr=0 next cycle, no done pulse; a new i_dump_start restarts from index 0.
